program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Serial program loader: receives a length-prefixed byte stream, writes 15-bit
// instruction words into instruction memory, verifies an XOR checksum and releases the CPU.
module program_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [14:0]       im_data,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [8:0]        word_count
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

  localparam logic [1:0] ERR_HIGH  = 2'b01;
  localparam logic [1:0] ERR_CSUM  = 2'b10;
  localparam logic [1:0] ERR_OVFL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, HEADER, HI, LO, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t           state, nxt;
  logic             ready_d, we_d, hold_d, done_d;
  logic [1:0]       rst_sync;
  logic             run, accept, restart, last_word, overflow;
  logic [CNT_W-1:0] total, total_c;
  logic [7:0]       checksum;

  // Deassertion synchroniser; the FSM stays frozen until it releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run       = rst_sync[1];
  assign accept    = byte_valid && byte_ready;
  assign total_c   = CNT_W'(byte_in) + CNT_W'(1);
  assign overflow  = total_c > MAX_WORDS;
  assign last_word = (word_count + CNT_W'(1)) == total;
  assign restart   = run && start && (state == IDLE || state == DONE || state == ERR);

  // State register; Moore outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= nxt;
      byte_ready <= ready_d;
      im_we      <= we_d;
      cpu_hold   <= hold_d;
      done       <= done_d;
    end
  end

  always_comb begin
    nxt = state;
    if (run) begin
      case (state)
        IDLE:    if (start) nxt = HEADER;
        HEADER:  if (accept) nxt = overflow ? ERR : HI;
        HI:      if (accept) nxt = byte_in[7] ? ERR : LO;
        LO:      if (accept) nxt = WRITE;
        WRITE:   nxt = last_word ? CHECK : HI;
        CHECK:   if (accept) nxt = (byte_in == checksum) ? DONE : ERR;
        DONE:    if (start) nxt = HEADER;
        ERR:     if (start) nxt = HEADER;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    hold_d  = 1'b1;
    done_d  = 1'b0;
    case (nxt)
      HEADER, HI, LO, CHECK: ready_d = 1'b1;
      WRITE:                 we_d    = 1'b1;
      DONE: begin
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Session datapath: word assembly, address/count, running checksum, error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_addr    <= '0;
      im_data    <= '0;
      word_count <= '0;
      total      <= '0;
      checksum   <= '0;
      err_code   <= 2'b00;
    end else if (restart) begin
      im_addr    <= '0;
      word_count <= '0;
      total      <= '0;
      checksum   <= '0;
      err_code   <= 2'b00;
    end else begin
      case (state)
        HEADER: if (accept) begin
          total    <= total_c;
          checksum <= checksum ^ byte_in;
          if (overflow) err_code <= ERR_OVFL;
        end
        HI: if (accept) begin
          if (byte_in[7]) begin
            err_code <= ERR_HIGH;
          end else begin
            im_data[14:8] <= byte_in[6:0];
            checksum      <= checksum ^ byte_in;
          end
        end
        LO: if (accept) begin
          im_data[7:0] <= byte_in;
          checksum     <= checksum ^ byte_in;
        end
        WRITE: begin
          im_addr    <= im_addr + ADDR_W'(1);
          word_count <= word_count + CNT_W'(1);
        end
        CHECK: if (accept && byte_in != checksum) err_code <= ERR_CSUM;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader (ADDR_W=4): a byte-stream reference model
// predicts writes, final status and error codes for each load session.
module tb_program_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [14:0]   im_data;
  logic          cpu_hold;
  logic          done;
  logic [1:0]    err_code;
  logic [8:0]    word_count;

  program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .im_we(im_we),
    .im_addr(im_addr), .im_data(im_data), .cpu_hold(cpu_hold), .done(done),
    .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write capture plus one-cycle write latency measurement.
  int cyc = 0;
  int last_hs = -10;
  logic [18:0] wr_q[$];

  always @(posedge clk) begin
    cyc++;
    if (byte_valid && byte_ready) last_hs = cyc;
  end

  always @(negedge clk) begin
    if (im_we) begin
      wr_q.push_back({im_addr, im_data});
      check("write_latency", 32'(last_hs), 32'(cyc));
    end
  end

  function automatic bq_t gen_prog(input int words, input int bad_idx, input bit good_ck);
    bq_t p;
    logic [7:0] cs, hi, lo;
    p.push_back(8'(words - 1));
    cs = 8'(words - 1);
    for (int w = 0; w < words; w++) begin
      hi = 8'($urandom_range(0, 127));
      if (w == bad_idx) hi = hi | 8'h80;
      lo = 8'($urandom);
      p.push_back(hi);
      p.push_back(lo);
      cs = cs ^ hi ^ lo;
    end
    p.push_back(good_ck ? cs : cs ^ 8'($urandom_range(1, 255)));
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse);
    int waited;
    bit sent;
    waited = 0;
    sent = 1'b0;
    while (!sent && waited < 40) begin
      @(negedge clk);
      start = 1'b0;
      waited++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in = b;
        if (pulse) start = 1'b1;
        if (byte_ready) sent = 1'b1;
      end
    end
    check("byte_accepted", 32'(sent), 32'd1);
  endtask

  task automatic session(input string tag, input bit do_start, input bit gaps,
                         input bit pulse_hi, input bq_t prog);
    logic [18:0] exp_w[$];
    logic [1:0]  exp_err;
    logic [7:0]  cs, hi, lo;
    int          total, n_send, nw;
    // Reference model: walk the byte list by the loader's rules.
    exp_err = 2'b00;
    total = int'(prog[0]) + 1;
    cs = prog[0];
    if (total > DEPTH) begin
      exp_err = 2'b11;
      n_send = 1;
    end else begin
      n_send = 2 + 2 * total;
      for (int w = 0; w < total; w++) begin
        hi = prog[1 + 2 * w];
        if (hi[7]) begin
          exp_err = 2'b01;
          n_send = 2 + 2 * w;
          break;
        end
        lo = prog[2 + 2 * w];
        cs = cs ^ hi ^ lo;
        exp_w.push_back({4'(w % DEPTH), hi[6:0], lo});
      end
      if (exp_err == 2'b00 && prog[1 + 2 * total] != cs) exp_err = 2'b10;
    end
    nw = exp_w.size();

    wr_q.delete();
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int i = 0; i < n_send; i++) send_byte(prog[i], gaps, pulse_hi && i == 1);
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);

    check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wr_q.size(); i++)
      check({tag, "_write"}, 32'(wr_q[i]), 32'(exp_w[i]));
    check({tag, "_err"}, 32'(err_code), 32'(exp_err));
    check({tag, "_done"}, 32'(done), 32'(exp_err == 2'b00));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_err != 2'b00));
    check({tag, "_count"}, 32'(word_count), 32'(nw));
    check({tag, "_addr"}, 32'(im_addr), 32'(nw % DEPTH));
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(im_we), 32'd0);
    check({tag, "_addr"}, 32'(im_addr), 32'd0);
    check({tag, "_data"}, 32'(im_data), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err_code), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    bq_t good, p;
    int kind, words, waited;
    good = {8'h01, 8'h12, 8'h34, 8'h05, 8'h67, 8'h45};

    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // Start held from release: the first edge must not move the FSM.
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("sync_first_edge", 32'(byte_ready), 32'd0);
    waited = 0;
    while (!byte_ready && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    check("sync_reaches_header", 32'(byte_ready), 32'd1);

    session("good", 1'b0, 1'b0, 1'b0, good);
    p = {8'h00, 8'h92};
    session("bad_hi", 1'b1, 1'b0, 1'b0, p);
    p = {8'h00, 8'h01, 8'h02, 8'hFF};
    session("csum_err", 1'b1, 1'b0, 1'b0, p);
    p = {8'h10};
    session("overflow", 1'b1, 1'b0, 1'b0, p);
    session("backpressure", 1'b1, 1'b1, 1'b1, good);
    session("full_depth", 1'b1, 1'b1, 1'b0, gen_prog(16, -1, 1'b1));

    // Reset while in LO of the second word.
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clk);
    check("midreset_writes", 32'(wr_q.size()), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    session("after_reset", 1'b1, 1'b0, 1'b0, good);

    for (int n = 0; n < 10; n++) begin
      kind = int'($urandom_range(0, 3));
      words = int'($urandom_range(1, DEPTH));
      case (kind)
        0: p = gen_prog(words, -1, 1'b1);
        1: p = gen_prog(words, int'($urandom_range(0, words - 1)), 1'b1);
        2: p = gen_prog(words, -1, 1'b0);
        default: p = gen_prog(int'($urandom_range(DEPTH + 1, 256)), -1, 1'b1);
      endcase
      session("random", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
